// File: rtl/instrumented_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// instrumented_adder_meas_ctrl
//
// Shared measurement controller for the instrumented-adder family. For each
// measurement it:
//   - drives the latched operands to every adder;
//   - checks the settled sum of the selected channel;
//   - opens that channel's ring-oscillator enable for a window of G cycles;
//   - counts synchronised tap edges, accumulating the counts over R runs.
//
// Ports:
//   wb_clk_i, wb_rst_n        clock, synchronous active-low reset
//   start, abort              begin a measurement / return to idle
//   chan_sel, gate_cycles,    configuration, latched when start is accepted
//   runs, a_operand, b_operand
//   a_input, b_input          operands broadcast to all adders
//   sum_in                    concatenated adder sums, channel k at [k*WIDTH +: WIDTH]
//   osc_tap                   asynchronous divided oscillator taps
//   osc_en                    one-hot oscillator enable (only during COUNT)
//   busy, done                status; done is a one-cycle result strobe
//   count_out, overflow, err  results, updated only when entering DONE
//   sum_out, sum_ok           sum captured at the end of each settle phase
// ---------------------------------------------------------------------------
module instrumented_adder_meas_ctrl #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int GATE_W   = 16,
  parameter int CNT_W    = 24,
  parameter int RUNS_W   = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ACC_W   = CNT_W + RUNS_W
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SEL_W-1:0]          chan_sel,
  input  logic [GATE_W-1:0]         gate_cycles,
  input  logic [RUNS_W-1:0]         runs,
  input  logic [WIDTH-1:0]          a_operand,
  input  logic [WIDTH-1:0]          b_operand,
  output logic [WIDTH-1:0]          a_input,
  output logic [WIDTH-1:0]          b_input,
  input  logic [CHANNELS*WIDTH-1:0] sum_in,
  input  logic [CHANNELS-1:0]       osc_tap,
  output logic [CHANNELS-1:0]       osc_en,
  output logic                      busy,
  output logic                      done,
  output logic [ACC_W-1:0]          count_out,
  output logic [WIDTH-1:0]          sum_out,
  output logic                      sum_ok,
  output logic                      overflow,
  output logic                      err
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_GAP, ST_DONE} state_t;

  localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W+1)'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              r_state;
  logic [GATE_W-1:0]   r_phase;
  logic [GATE_W-1:0]   r_gate;
  logic [RUNS_W-1:0]   r_runs_left;
  logic [SEL_W-1:0]    r_chan;
  logic [WIDTH-1:0]    r_a_input;
  logic [WIDTH-1:0]    r_b_input;
  logic [CNT_W-1:0]    r_run_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf_sticky;
  logic                r_err_pend;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_sync3;
  logic [CHANNELS-1:0] r_osc_en;
  logic                r_busy;
  logic                r_done;
  logic [ACC_W-1:0]    r_count_out;
  logic [WIDTH-1:0]    r_sum_out;
  logic                r_sum_ok;
  logic                r_overflow;
  logic                r_err;

  // Sum table padded to a power of two so any r_chan value indexes a real entry.
  logic [WIDTH-1:0]    w_sum_arr [2**SEL_W];
  logic [CHANNELS-1:0] w_onehot;

  for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_sum
    if (gi < CHANNELS) begin : g_real
      assign w_sum_arr[gi] = sum_in[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_sum_arr[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
    assign w_onehot[gi] = (r_chan == SEL_W'(gi));
  end

  logic [WIDTH-1:0] w_sum_sel;
  logic [WIDTH-1:0] w_exp_sum;
  logic [ACC_W-1:0] w_acc_sum;
  logic             w_edge_sel;
  logic             w_start_inval;

  assign w_sum_sel     = w_sum_arr[r_chan];
  assign w_exp_sum     = r_a_input + r_b_input;
  assign w_acc_sum     = r_acc + ACC_W'(r_run_cnt);
  // r_sync3 is the previous synchronised level; rising edge = now high, was low.
  assign w_edge_sel    = |(r_sync2 & ~r_sync3 & w_onehot);
  assign w_start_inval = ({1'b0, chan_sel} >= CHAN_LIM);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_gate       <= '0;
      r_runs_left  <= '0;
      r_chan       <= '0;
      r_a_input    <= '0;
      r_b_input    <= '0;
      r_run_cnt    <= '0;
      r_acc        <= '0;
      r_ovf_sticky <= 1'b0;
      r_err_pend   <= 1'b0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_sync3      <= '0;
      r_osc_en     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count_out  <= '0;
      r_sum_out    <= '0;
      r_sum_ok     <= 1'b0;
      r_overflow   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sync1 <= osc_tap;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_done  <= 1'b0;

      if (abort) begin
        // Results are left untouched; only the sequencing is dropped.
        r_state   <= ST_IDLE;
        r_osc_en  <= '0;
        r_busy    <= 1'b0;
        r_run_cnt <= '0;
        r_phase   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_a_input    <= a_operand;
              r_b_input    <= b_operand;
              r_chan       <= chan_sel;
              r_gate       <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
              r_runs_left  <= (runs == '0) ? RUNS_W'(1) : runs;
              r_acc        <= '0;
              r_ovf_sticky <= 1'b0;
              r_run_cnt    <= '0;
              r_phase      <= '0;
              r_busy       <= 1'b1;
              if (w_start_inval) begin
                // Nothing to measure: report the error straight away.
                r_err_pend  <= 1'b1;
                r_state     <= ST_DONE;
                r_done      <= 1'b1;
                r_count_out <= '0;
                r_overflow  <= 1'b0;
                r_err       <= 1'b1;
              end else begin
                r_err_pend <= 1'b0;
                r_state    <= ST_SETTLE;
              end
            end
          end

          ST_SETTLE: begin
            if (r_phase == GATE_W'(3)) begin
              r_sum_out <= w_sum_sel;
              r_sum_ok  <= (w_sum_sel == w_exp_sum);
              r_phase   <= '0;
              r_osc_en  <= w_onehot;
              r_state   <= ST_COUNT;
            end else begin
              r_phase <= r_phase + GATE_W'(1);
            end
          end

          ST_COUNT: begin
            if (w_edge_sel && (r_run_cnt != CNT_MAX)) begin
              r_run_cnt <= r_run_cnt + CNT_W'(1);
              if (r_run_cnt == CNT_MAX - CNT_W'(1)) r_ovf_sticky <= 1'b1;
            end
            if (r_phase == r_gate - GATE_W'(1)) begin
              r_phase  <= '0;
              r_osc_en <= '0;
              r_state  <= ST_GAP;
            end else begin
              r_phase <= r_phase + GATE_W'(1);
            end
          end

          ST_GAP: begin
            if (r_phase == GATE_W'(1)) begin
              r_acc       <= w_acc_sum;
              r_run_cnt   <= '0;
              r_phase     <= '0;
              r_runs_left <= r_runs_left - RUNS_W'(1);
              if (r_runs_left == RUNS_W'(1)) begin
                // Results become visible together with the done strobe.
                r_state     <= ST_DONE;
                r_done      <= 1'b1;
                r_count_out <= w_acc_sum;
                r_overflow  <= r_ovf_sticky;
                r_err       <= r_err_pend;
              end else begin
                r_state <= ST_SETTLE;
              end
            end else begin
              r_phase <= r_phase + GATE_W'(1);
            end
          end

          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end

          default: begin
            r_busy   <= 1'b0;
            r_osc_en <= '0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign a_input   = r_a_input;
  assign b_input   = r_b_input;
  assign osc_en    = r_osc_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count_out = r_count_out;
  assign sum_out   = r_sum_out;
  assign sum_ok    = r_sum_ok;
  assign overflow  = r_overflow;
  assign err       = r_err;

endmodule

// File: tb/tb_instrumented_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instrumented_adder_meas_ctrl
//
// Scoreboard bench. Stimulus launches measurements and pushes the expected
// results (done cycle, count range, flags, sum, oscillator-enable activity).
// It also pushes expected output snapshots for chosen cycles. A monitor pops
// and compares on every done pulse and at every snapshot cycle. The DUT uses
// CHANNELS=3 and CNT_W=4 so that the invalid channel and saturation cases
// are reachable.
// ---------------------------------------------------------------------------
module tb_instrumented_adder_meas_ctrl;

  localparam int WIDTH = 32;
  localparam int CH    = 3;
  localparam int CNTW  = 4;
  localparam int ACCW  = CNTW + 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [1:0]        chan_sel;
  logic [15:0]       gate_cycles;
  logic [3:0]        runs;
  logic [WIDTH-1:0]  a_operand, b_operand, a_input, b_input, sum_out;
  logic [CH*WIDTH-1:0] sum_in;
  logic [CH-1:0]     osc_tap, osc_en;
  logic              busy, done, sum_ok, overflow, err;
  logic [ACCW-1:0]   count_out;

  instrumented_adder_meas_ctrl #(
    .WIDTH(WIDTH), .CHANNELS(CH), .GATE_W(16), .CNT_W(CNTW), .RUNS_W(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
    .chan_sel(chan_sel), .gate_cycles(gate_cycles), .runs(runs),
    .a_operand(a_operand), .b_operand(b_operand),
    .a_input(a_input), .b_input(b_input), .sum_in(sum_in),
    .osc_tap(osc_tap), .osc_en(osc_en), .busy(busy), .done(done),
    .count_out(count_out), .sum_out(sum_out), .sum_ok(sum_ok),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Taps: channel 2 period 4 clocks, channels 0/1 slower (periods 8 and 16).
  logic [7:0] tick = '0;
  always @(negedge clk) begin
    tick    = tick + 8'd1;
    osc_tap = {tick[1], tick[3], tick[2]};
  end

  typedef struct {
    string       nm;
    int          exp_cyc;
    int          lo, hi;
    bit          ovf, er, ok;
    logic [31:0] sum, a;
    int          en;
    logic [2:0]  mask;
  } done_t;

  typedef struct {
    string       nm;
    int          at;
    logic [2:0]  oen;
    bit          bsy, dn, er, ovf, ok;
    logic [7:0]  cnt;
    logic [31:0] sum, a, b;
  } snap_t;

  done_t sb[$];
  snap_t snaps[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  int         en_cnt = 0;
  logic [2:0] en_or  = '0;
  done_t      e;
  snap_t      sn;

  always @(negedge clk) begin
    if (!busy) begin
      en_cnt = 0;
      en_or  = '0;
    end else if (osc_en != '0) begin
      en_cnt++;
      en_or |= osc_en;
    end

    if (snaps.size() != 0 && snaps[0].at == cyc) begin
      sn = snaps.pop_front();
      cmp({sn.nm, ".osc_en"},    64'(osc_en),    64'(sn.oen));
      cmp({sn.nm, ".busy"},      64'(busy),      64'(sn.bsy));
      cmp({sn.nm, ".done"},      64'(done),      64'(sn.dn));
      cmp({sn.nm, ".count_out"}, 64'(count_out), 64'(sn.cnt));
      cmp({sn.nm, ".err"},       64'(err),       64'(sn.er));
      cmp({sn.nm, ".overflow"},  64'(overflow),  64'(sn.ovf));
      cmp({sn.nm, ".sum_out"},   64'(sum_out),   64'(sn.sum));
      cmp({sn.nm, ".sum_ok"},    64'(sum_ok),    64'(sn.ok));
      cmp({sn.nm, ".a_input"},   64'(a_input),   64'(sn.a));
      cmp({sn.nm, ".b_input"},   64'(b_input),   64'(sn.b));
    end

    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        e = sb.pop_front();
        cmp({e.nm, ".done_cycle"}, 64'(cyc), 64'(e.exp_cyc));
        n_vec++;
        if (int'(count_out) < e.lo || int'(count_out) > e.hi) begin
          n_bad++;
          $display("FAIL %s.count_out: got %0d, want %0d..%0d", e.nm, count_out, e.lo, e.hi);
        end
        cmp({e.nm, ".overflow"},  64'(overflow), 64'(e.ovf));
        cmp({e.nm, ".err"},       64'(err),      64'(e.er));
        cmp({e.nm, ".sum_out"},   64'(sum_out),  64'(e.sum));
        cmp({e.nm, ".sum_ok"},    64'(sum_ok),   64'(e.ok));
        cmp({e.nm, ".a_input"},   64'(a_input),  64'(e.a));
        cmp({e.nm, ".en_cycles"}, 64'(en_cnt),   64'(e.en));
        cmp({e.nm, ".en_bits"},   64'(en_or),    64'(e.mask));
      end
    end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s.done_timeout: got no done by cycle %0d, want done at %0d", e.nm, cyc, e.exp_cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input string nm, input logic [1:0] ch, input int g, input int r,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] s2,
                        input bit push, input int lo, input int hi, input bit eovf,
                        input bit eerr, input logic [31:0] esum, input bit eok,
                        output int s);
    done_t d;
    int    rr, gg;
    @(negedge clk);
    chan_sel    = ch;
    gate_cycles = 16'(g);
    runs        = 4'(r);
    a_operand   = a;
    b_operand   = b;
    sum_in      = {s2, 32'hBEEF_0001, 32'hDEAD_0000};
    start       = 1'b1;
    s           = cyc;
    if (push) begin
      rr     = (r == 0) ? 1 : r;
      gg     = (g == 0) ? 1 : g;
      d.nm   = nm;
      d.exp_cyc = eerr ? s + 1 : s + 1 + rr * (6 + gg);
      d.lo   = lo;
      d.hi   = hi;
      d.ovf  = eovf;
      d.er   = eerr;
      d.ok   = eok;
      d.sum  = esum;
      d.a    = a;
      d.en   = eerr ? 0 : rr * gg;
      d.mask = eerr ? 3'b000 : (3'b001 << ch);
      sb.push_back(d);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && (sb.size() != 0 || snaps.size() != 0); k++) @(negedge clk);
  endtask

  function automatic snap_t mk(input string nm, input int at, input logic [2:0] oen, input bit bsy,
                               input logic [7:0] cnt, input bit er, input bit ovf,
                               input logic [31:0] sum, input bit ok,
                               input logic [31:0] a, input logic [31:0] b);
    snap_t t;
    t.nm = nm; t.at = at; t.oen = oen; t.bsy = bsy; t.dn = 1'b0; t.cnt = cnt;
    t.er = er; t.ovf = ovf; t.sum = sum; t.ok = ok; t.a = a; t.b = b;
    return t;
  endfunction

  int s;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chan_sel = '0; gate_cycles = '0;
    runs = '0; a_operand = '0; b_operand = '0; sum_in = '0;
    repeat (2) @(negedge clk);
    snaps.push_back(mk("reset", cyc + 1, 3'b000, 0, 8'd0, 0, 0, 32'd0, 0, 32'd0, 32'd0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch("basic",     2'd2, 20, 1, 32'd5, 32'd7, 32'd12, 1, 4, 6, 0, 0, 32'd12, 1, s); drain();
    launch("multi_run", 2'd2, 20, 3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 12, 18, 0, 0, 32'd0, 1, s); drain();
    launch("sum_bad",   2'd2, 20, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 4, 6, 0, 0, 32'd1, 0, s); drain();
    launch("gate_zero", 2'd2, 0, 2, 32'd3, 32'd4, 32'd7, 1, 0, 2, 0, 0, 32'd7, 1, s); drain();
    launch("runs_zero", 2'd2, 4, 0, 32'd10, 32'd20, 32'd31, 1, 0, 2, 0, 0, 32'd31, 0, s); drain();
    launch("saturate",  2'd2, 100, 1, 32'd1, 32'd2, 32'd3, 1, 15, 15, 1, 0, 32'd3, 1, s); drain();
    launch("ovf_clear", 2'd2, 20, 1, 32'd8, 32'd8, 32'd16, 1, 4, 6, 0, 0, 32'd16, 1, s); drain();
    launch("bad_chan",  2'd3, 20, 1, 32'd8, 32'd8, 32'd16, 1, 0, 0, 0, 1, 32'd16, 1, s); drain();

    // Abort mid-COUNT: enable drops next cycle, no done, results retained.
    launch("abort", 2'd2, 20, 1, 32'd9, 32'd9, 32'd18, 0, 0, 0, 0, 0, 32'd0, 0, s);
    snaps.push_back(mk("abort_pre",  s + 10, 3'b100, 1, 8'd0, 1, 0, 32'd18, 1, 32'd9, 32'd9));
    snaps.push_back(mk("abort_post", s + 11, 3'b000, 0, 8'd0, 1, 0, 32'd18, 1, 32'd9, 32'd9));
    while (cyc < s + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    drain();

    // Start pulsed during SETTLE must not disturb the running measurement.
    launch("busy_start", 2'd2, 20, 1, 32'd100, 32'd23, 32'd123, 1, 4, 6, 0, 0, 32'd123, 1, s);
    @(negedge clk);
    chan_sel = 2'd0; gate_cycles = 16'd5; runs = 4'd3;
    a_operand = 32'd1; b_operand = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-run clears every output.
    launch("mid_reset", 2'd2, 20, 1, 32'd50, 32'd50, 32'd100, 0, 0, 0, 0, 0, 32'd0, 0, s);
    snaps.push_back(mk("mid_reset", s + 11, 3'b000, 0, 8'd0, 0, 0, 32'd0, 0, 32'd0, 32'd0));
    while (cyc < s + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    launch("after_reset", 2'd2, 20, 1, 32'd5, 32'd7, 32'd12, 1, 4, 6, 0, 0, 32'd12, 1, s); drain();

    repeat (5) @(negedge clk);
    if (sb.size() != 0 || snaps.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size() + snaps.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_meas_ctrl.md
# instrumented_adder_meas_ctrl

Parametrised measurement controller for the instrumented-adder family. It drives operands into one of `CHANNELS` adder instances, checks the settled sum, and gates that channel's ring-oscillator enable for a programmable window. It counts synchronised oscillator-tap edges and accumulates the counts over a programmable number of runs. It sits between the logic-analyser register bank and the adder/ring-oscillator macros. It replaces per-adder hand-wired count logic with one shared, multi-run, checked controller.

## Interface
Parameters:
- `WIDTH`, 32, adder operand/sum width
- `CHANNELS`, 4, number of adder instances (≥1); `SEL_W = max(1, $clog2(CHANNELS))`
- `GATE_W`, 16, width of gate-window length
- `CNT_W`, 24, per-run edge counter width
- `RUNS_W`, 4, width of run-count field; accumulator width `ACC_W = CNT_W + RUNS_W`

Ports:
- `wb_clk_i`  in  1  system clock
- `wb_rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin measurement; sampled in IDLE only
- `abort`  in  1  return to IDLE next cycle from any state
- `chan_sel`  in  SEL_W  channel to measure, latched at start
- `gate_cycles`  in  GATE_W  count window length G, latched at start
- `runs`  in  RUNS_W  number of runs R, latched at start
- `a_operand`, `b_operand`  in  WIDTH  operands, latched at start
- `a_input`, `b_input`  out  WIDTH  operands broadcast to all adders
- `sum_in`  in  CHANNELS*WIDTH  adder sums; channel k at `[k*WIDTH +: WIDTH]`
- `osc_tap`  in  CHANNELS  divided ring-oscillator taps, asynchronous
- `osc_en`  out  CHANNELS  one-hot oscillator enable
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse, results valid
- `count_out`  out  ACC_W  accumulated edge count
- `sum_out`  out  WIDTH  sum captured on the last run
- `sum_ok`  out  1  `sum_out == (a+b) mod 2^WIDTH`
- `overflow`  out  1  a per-run counter saturated
- `err`  out  1  invalid `chan_sel`

## Operation
- Reset state:
  - FSM in IDLE.
  - `osc_en`=0, `a_input`=`b_input`=0, `busy`=`done`=0.
  - `count_out`=0, `sum_out`=0, `sum_ok`=0, `overflow`=0, `err`=0.
  - Synchroniser flops cleared.
- All `osc_tap` bits pass through a 2-flop synchroniser and a rising-edge detector. Only the selected channel's edge pulse is counted.
- Latching at start: `start` in IDLE latches the config.
  - Effective R = `runs` when `runs` ≠ 0, else 1.
  - Effective G = `gate_cycles` when `gate_cycles` ≠ 0, else 1.
  - `a_input`/`b_input` take the latched operands and hold them until the next accepted start.
  - The accumulator and overflow-sticky flag clear.
- FSM states:
  - IDLE → SETTLE on `start`. If `chan_sel` ≥ CHANNELS, go IDLE → DONE instead, with `err`=1, `count_out`=0 and `overflow`=0.
  - SETTLE: 4 cycles, `osc_en`=0. On the 4th cycle capture `sum_in[chan]` into `sum_out` and compute `sum_ok`.
  - COUNT: G cycles. `osc_en[chan]`=1, all other bits 0. The run counter increments on each detected edge and saturates at 2^CNT_W−1; at saturation it sets the overflow sticky flag.
  - GAP: 2 cycles, `osc_en`=0. Edges detected here are not counted. On the last GAP cycle the run count is added to the accumulator and the run counter clears. Then go to SETTLE if runs remain, else DONE.
  - DONE: 1 cycle. `done`=1. `count_out`, `overflow` and `err` update from internal state. Next state IDLE.
- Result registers:
  - `count_out`, `overflow` and `err` change only in DONE, and hold until the next DONE.
  - `sum_out`/`sum_ok` update at each SETTLE capture.
- Accumulator arithmetic:
  - The accumulator is ACC_W wide and is a plain unsigned add.
  - It cannot wrap: R ≤ 2^RUNS_W−1, and each run count ≤ 2^CNT_W−1.
- Abort:
  - Next state is IDLE and `osc_en`=0 immediately.
  - No `done` pulse; `count_out`, `overflow` and `err` are unchanged.
  - `abort` takes priority over `start` in the same cycle.
- `start` while `busy` is ignored.
- Reset mid-run behaves as the reset state above. The result registers clear.

## Timing
- Start accepted at edge 0; the first SETTLE cycle is cycle 1.
- `done` is high in cycle `1 + R*(6+G)`. `busy` is high from cycle 1 through that DONE cycle.
- Edge-to-count latency is 3 cycles (2 synchroniser flops + edge register). Only edges whose detector pulse lands inside COUNT are counted.
- The tap must stay high and low for ≥2 clocks each. Faster taps alias; this is not detected.
- `osc_en` changes on the clock edge entering or leaving COUNT; it has no combinational path from inputs.
- A new measurement may start in the cycle after DONE.

## Test plan
- Basic count: CHANNELS=4, chan_sel=2, G=20, R=1; tap[2] toggles every 2 clocks (period 4) → `done` at cycle 27, `count_out`=5±1, `osc_en`=4'b0100 only in COUNT, `overflow`=0.
- Multi-run accumulate: same tap, G=20, R=3 → `done` at cycle 79, `count_out` = sum of three runs (15±3). A G=0 variant measures with G=1.
- Sum check: a=32'hFFFFFFFF, b=1, sum_in[2]=0 → `sum_out`=0, `sum_ok`=1. With sum_in[2]=32'h1 → `sum_ok`=0.
- Saturation: CNT_W=4, tap period 4, G=100, R=1 → `count_out`=15, `overflow`=1.
- Invalid channel: CHANNELS=3, chan_sel=3 → `done` at cycle 1, `err`=1, `count_out`=0, `osc_en` never asserted.
- Abort and busy-start:
  - `abort` in COUNT → `osc_en`=0 next cycle, no `done`, prior `count_out` retained.
  - `start` pulsed during SETTLE → ignored, config unchanged.
  - `wb_rst_n`=0 mid-run → all outputs 0 next cycle.
